// File: rtl/count_serializer.sv
// rtl/count_serializer.sv - 4-bit count framer: start, d0..d3, even parity, stop on an idle-high line.
// Every output comes straight from a flop; each frame bit is held for BIT_CYCLES clocks.
module count_serializer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count_in,
   input  logic       capture,
   input  logic       overrun_clr,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [2:0] IDX_LAST = 3'd6;

   state_t     state_q, state_d;
   logic [7:0] cyc_q, cyc_d;
   logic [2:0] idx_q, idx_d;
   logic [5:0] shreg_q, shreg_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       overrun_q, overrun_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cyc_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;

      // A set on the same edge as a clear must win, so it is applied last.
      if (overrun_clr) overrun_d = 1'b0;
      if (capture && busy_q) overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (capture) begin
               state_d = SHIFT;
               shreg_d = {1'b1, ^count_in, count_in};
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cyc_d   = '0;
               idx_d   = '0;
            end
         end
         SHIFT: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Data, parity and stop drain LSB first out of the shift register.
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b1, shreg_q[5:1]};
               end
            end else begin
               cyc_d = cyc_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_count_serializer.sv
// tb/tb_count_serializer.sv - directed checks of count_serializer at BIT_CYCLES=4 and BIT_CYCLES=1.
module tb_count_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] count_a, count_b;
   logic       cap_a, cap_b, clr_a, clr_b;
   logic       tx_a, busy_a, done_a, ovr_a;
   logic       tx_b, busy_b, done_b, ovr_b;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   count_serializer #(.BIT_CYCLES(4)) dut_a (
      .clk(clk), .reset(reset), .count_in(count_a), .capture(cap_a), .overrun_clr(clr_a),
      .tx(tx_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
   );

   count_serializer #(.BIT_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .count_in(count_b), .capture(cap_b), .overrun_clr(clr_b),
      .tx(tx_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks frame cycles first..28 of dut_a (cycle 1 follows the capture edge), then the done cycle.
   task automatic check_from(input int first, input logic [6:0] exp);
      for (int c = first; c <= 28; c++) begin
         check($sformatf("a_tx c%0d", c), tx_a, exp[(c - 1) / 4]);
         check($sformatf("a_busy c%0d", c), busy_a, 1'b1);
         check($sformatf("a_done c%0d", c), done_a, 1'b0);
         tick();
      end
      check("a_done_pulse", done_a, 1'b1);
      check("a_done_busy", busy_a, 1'b0);
      check("a_done_tx", tx_a, 1'b1);
   endtask

   // Ends in the done cycle, so a following call starts a back-to-back frame.
   task automatic frame_a(input logic [3:0] d, input logic [6:0] exp);
      count_a = d;
      cap_a = 1'b1;
      tick();
      cap_a = 1'b0;
      count_a = ~d;
      check_from(1, exp);
   endtask

   initial begin
      logic saw_done;
      reset = 1'b1;
      count_a = '0; count_b = '0;
      cap_a = 1'b0; cap_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      tick();
      cap_a = 1'b1;
      tick();
      cap_a = 1'b0;
      check("rst_tx", tx_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_ovr", ovr_a, 1'b0);
      reset = 1'b0;
      tick();
      check("idle_busy", busy_a, 1'b0);

      frame_a(4'b1011, 7'b1110110);
      frame_a(4'h5, 7'b1001010);
      tick();
      check("idle_after_b2b", done_a, 1'b0);
      frame_a(4'b0000, 7'b1000000);
      tick();
      frame_a(4'b1111, 7'b1011110);
      tick();

      // Overrun: capture at cycle 10, then clr+capture together, then clr alone.
      count_a = 4'b1011;
      cap_a = 1'b1;
      tick();
      cap_a = 1'b0;
      repeat (9) tick();
      count_a = 4'b0000;
      cap_a = 1'b1;
      tick();
      cap_a = 1'b0;
      check("ovr_set", ovr_a, 1'b1);
      cap_a = 1'b1; clr_a = 1'b1;
      tick();
      cap_a = 1'b0; clr_a = 1'b0;
      check("ovr_set_wins", ovr_a, 1'b1);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      check("ovr_clr", ovr_a, 1'b0);
      check_from(13, 7'b1110110);
      tick();

      // Reset abort at cycle 12 with overrun set and capture held.
      count_a = 4'b1011;
      cap_a = 1'b1;
      tick();
      tick();
      cap_a = 1'b0;
      check("abort_ovr_pre", ovr_a, 1'b1);
      repeat (10) tick();
      reset = 1'b1; cap_a = 1'b1;
      tick();
      reset = 1'b0; cap_a = 1'b0;
      check("abort_tx", tx_a, 1'b1);
      check("abort_busy", busy_a, 1'b0);
      check("abort_ovr", ovr_a, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         saw_done = saw_done | done_a | busy_a;
         tick();
      end
      check("abort_no_done", saw_done, 1'b0);
      frame_a(4'b0110, 7'b1001100);

      // BIT_CYCLES=1: 0110 -> 0,0,1,1,0,0,1 then done.
      count_b = 4'b0110;
      cap_b = 1'b1;
      tick();
      cap_b = 1'b0;
      count_b = 4'b1001;
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("b_tx c%0d", c), tx_b, logic'((7'b1001100 >> (c - 1)) & 7'd1));
         check($sformatf("b_busy c%0d", c), busy_b, 1'b1);
         tick();
      end
      check("b_done", done_b, 1'b1);
      check("b_done_tx", tx_b, 1'b1);
      check("b_done_busy", busy_b, 1'b0);
      tick();
      check("b_done_once", done_b, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/count_serializer.md
COUNT_SERIALIZER -- requirements
Module: count_serializer

Interface
REQ-001 Parameter: BIT_CYCLES, default 4, clk cycles per serial bit; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 count_in  input  4  counter value to transmit, sampled only on an accepted capture.
REQ-005 capture  input  1  request: latch count_in and start a frame; level-sampled every clk edge.
REQ-006 overrun_clr  input  1  clears the overrun flag.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  single-cycle pulse marking frame completion.
REQ-010 overrun  output  1  sticky flag: capture was asserted while busy.

Function
REQ-011 The frame SHALL be 7 bits in this order: start (0), count bits d0..d3 (LSB first), even parity, stop (1).
REQ-012 Parity SHALL be the XOR of the 4 latched data bits, so the total number of ones across data plus parity is even.
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 In IDLE: tx=1 and busy=0.
REQ-015 In IDLE, capture=1 at edge k SHALL latch count_in at edge k and enter SHIFT.
REQ-016 From edge k+1, tx SHALL drive the start bit and busy SHALL be 1.
REQ-017 Each frame bit SHALL be held on tx for exactly BIT_CYCLES clk cycles.
REQ-018 Total frame duration SHALL be 7*BIT_CYCLES cycles.
REQ-019 A bit-cycle counter SHALL run 0..BIT_CYCLES-1.
REQ-020 A bit index SHALL run 0..6 and advance when the bit-cycle counter wraps.
REQ-021 At the edge that ends the last stop-bit cycle, the FSM SHALL return to IDLE.
REQ-022 In the cycle after that edge: done=1 for exactly one cycle, busy=0, tx=1.
REQ-023 A capture sampled in the done cycle SHALL be accepted (back-to-back frames), giving a start bit on the following cycle.
REQ-024 count_in changes during SHIFT SHALL NOT affect the frame in flight.
REQ-025 capture=1 on any edge while busy=1 SHALL be ignored for data and SHALL set overrun at that edge.
REQ-026 overrun_clr=1 SHALL clear overrun at the next edge.
REQ-027 If overrun set and overrun_clr occur at the same edge, set SHALL win.
REQ-028 With BIT_CYCLES=1, each bit SHALL last one cycle and the frame 7 cycles, with no gaps.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, tx=1, busy=0, done=0, overrun=0, and zero both counters and the shift register.
REQ-031 reset SHALL take priority over capture and overrun_clr.
REQ-032 reset asserted mid-frame SHALL abort the frame, and no done pulse SHALL be generated for it.
REQ-033 While reset=1, captures SHALL be ignored.

Verification
REQ-034 Basic frame: BIT_CYCLES=4, count_in=4'b1011, 1-cycle capture -> tx sequence 0,1,1,0,1,1,1, each held 4 cycles; busy high for 28 cycles; done pulses on cycle 29 after capture.
REQ-035 Parity zero case: count_in=4'b0000 -> data bits 0,0,0,0, parity 0; count_in=4'b1111 -> data bits 1,1,1,1, parity 0.
REQ-036 Back-to-back: capture asserted in the done cycle with count_in=4'h5 -> next start bit the following cycle; no idle gap; second frame 0,1,0,1,0,0,1.
REQ-037 Overrun handling: capture pulsed at cycle 10 of a frame -> overrun=1, frame data unchanged; overrun_clr and a second busy capture on the same edge -> overrun stays 1; overrun_clr alone -> overrun=0.
REQ-038 Reset abort: reset at cycle 12 of a frame -> tx=1, busy=0, overrun=0 after that edge; no done; a fresh capture afterwards produces a complete, correct frame.
REQ-039 Minimum divider: BIT_CYCLES=1, count_in=4'b0110 -> tx 0,0,1,1,0,0,1 on 7 consecutive cycles; done on the 8th.
